// File: rtl/merlin_lsq_pkg.sv
// Shared types and RV32I load/store encodings for the Merlin32 load/store queue.
// Queue entries carry everything needed to issue and later retire one memory op.
package merlin_lsq_pkg;

  localparam int LSQ_XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic                wr;
    logic [2:0]          funct3;
    logic [1:0]          hpl;
    logic [4:0]          regd;
    logic [LSQ_XLEN-1:0] addr;
    logic [LSQ_XLEN-1:0] data;
  } lsq_entry_t;

endpackage

// File: rtl/merlin_lsq_if.sv
// Hart data port: request (dreq*) and in-order response (drsp*) channels.
// master = load/store queue side, slave = memory/bus side.
interface merlin_lsq_if
  import merlin_lsq_pkg::*;
();

  logic                dreqready;
  logic                dreqvalid;
  logic [1:0]          dreqhpl;
  logic [LSQ_XLEN-1:0] dreqaddr;
  logic                dreqwr;
  logic [3:0]          dreqbe;
  logic [LSQ_XLEN-1:0] dreqwdata;
  logic                drspready;
  logic                drspvalid;
  logic                drsprerr;
  logic                drspwerr;
  logic [LSQ_XLEN-1:0] drspdata;

  modport master (
    input  dreqready,
    output dreqvalid, dreqhpl, dreqaddr,
    output dreqwr, dreqbe, dreqwdata,
    output drspready,
    input  drspvalid, drsprerr, drspwerr,
    input  drspdata
  );

  modport slave (
    output dreqready,
    input  dreqvalid, dreqhpl, dreqaddr,
    input  dreqwr, dreqbe, dreqwdata,
    input  drspready,
    output drspvalid, drsprerr, drspwerr,
    output drspdata
  );

endinterface

// File: rtl/merlin_lsq_align.sv
// Lane formatting: store byte enables / replicated data, load extract and
// sign/zero extension. Purely combinational.
module merlin_lsq_align
  import merlin_lsq_pkg::*;
(
  input  logic [2:0]          st_funct3_i,
  input  logic [1:0]          st_off_i,
  input  logic [LSQ_XLEN-1:0] st_data_i,
  output logic [3:0]          st_be_o,
  output logic [LSQ_XLEN-1:0] st_wdata_o,
  input  logic [2:0]          ld_funct3_i,
  input  logic [1:0]          ld_off_i,
  input  logic [LSQ_XLEN-1:0] ld_raw_i,
  output logic [LSQ_XLEN-1:0] ld_data_o
);

  logic [LSQ_XLEN-1:0] ld_sh;

  always_comb begin
    st_be_o    = 4'hF;
    st_wdata_o = st_data_i;
    unique case (st_funct3_i)
      F3_SB: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      F3_SH: begin
        st_be_o    = 4'b0011 << st_off_i;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        st_be_o    = 4'hF;
        st_wdata_o = st_data_i;
      end
    endcase
  end

  // Ops are naturally aligned, so shifting by the byte offset lands the
  // addressed field in the low lanes for every size.
  assign ld_sh = ld_raw_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_data_o = ld_sh;
    unique case (ld_funct3_i)
      F3_LB:   ld_data_o = {{24{ld_sh[7]}}, ld_sh[7:0]};
      F3_LH:   ld_data_o = {{16{ld_sh[15]}}, ld_sh[15:0]};
      F3_LBU:  ld_data_o = {24'h0, ld_sh[7:0]};
      F3_LHU:  ld_data_o = {16'h0, ld_sh[15:0]};
      default: ld_data_o = ld_sh;
    endcase
  end

endmodule

// File: rtl/merlin_lsq.sv
// Merlin32 load/store queue: in-order issue on the data port, load writeback, bus errors.
// MERLIN_LSQ_MULTI_OUTSTANDING_EN allows up to DEPTH requests in flight (default: one).
module merlin_lsq
  import merlin_lsq_pkg::*;
#(
  parameter int C_XLEN    = LSQ_XLEN,
  parameter int C_DEPTH_X = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clk_en_i,
  output logic              exs_full_o,
  input  logic              exs_lq_wr_i,
  input  logic              exs_sq_wr_i,
  input  logic [2:0]        exs_funct3_i,
  input  logic [1:0]        exs_hpl_i,
  input  logic [4:0]        exs_regd_addr_i,
  input  logic [C_XLEN-1:0] exs_regs2_data_i,
  input  logic [C_XLEN-1:0] exs_addr_i,
  merlin_lsq_if.master      dbus,
  output logic              ids_reg_wr_o,
  output logic [4:0]        ids_reg_addr_o,
  output logic [C_XLEN-1:0] ids_reg_data_o,
  output logic              hvec_lerr_o,
  output logic              hvec_serr_o,
  output logic [C_XLEN-1:0] hvec_err_addr_o
);

  localparam int DEPTH = 1 << C_DEPTH_X;
  localparam int PW    = C_DEPTH_X + 1;

  typedef logic [PW-1:0] ptr_t;

  lsq_entry_t mem_q [DEPTH];
  lsq_entry_t mem_d [DEPTH];

  ptr_t wr_q, wr_d;
  ptr_t iss_q, iss_d;
  ptr_t rsp_q, rsp_d;
  ptr_t count;

  logic [C_DEPTH_X-1:0] wr_idx;
  logic [C_DEPTH_X-1:0] iss_idx;
  logic [C_DEPTH_X-1:0] rsp_idx;

  logic              enq;
  logic              issue_ok;
  logic              iss_fire;
  logic              rsp_fire;
  logic [3:0]        st_be;
  logic [C_XLEN-1:0] st_wdata;
  logic [C_XLEN-1:0] ld_data;

  logic              ids_wr_q, ids_wr_d;
  logic [4:0]        ids_addr_q, ids_addr_d;
  logic [C_XLEN-1:0] ids_data_q, ids_data_d;
  logic              lerr_q, lerr_d;
  logic              serr_q, serr_d;
  logic [C_XLEN-1:0] eaddr_q, eaddr_d;

  assign wr_idx  = wr_q[C_DEPTH_X-1:0];
  assign iss_idx = iss_q[C_DEPTH_X-1:0];
  assign rsp_idx = rsp_q[C_DEPTH_X-1:0];

  // An entry stays allocated until its response retires it.
  assign count      = wr_q - rsp_q;
  assign exs_full_o = (count == ptr_t'(DEPTH));
  assign enq        = (exs_lq_wr_i | exs_sq_wr_i)
                    & clk_en_i & ~exs_full_o;

`ifdef MERLIN_LSQ_MULTI_OUTSTANDING_EN
  assign issue_ok = 1'b1;
`else
  assign issue_ok = (iss_q == rsp_q);
`endif

  assign dbus.dreqvalid = (iss_q != wr_q) & issue_ok;
  assign dbus.dreqhpl   = mem_q[iss_idx].hpl;
  assign dbus.dreqaddr  = {mem_q[iss_idx].addr[C_XLEN-1:2], 2'b00};
  assign dbus.dreqwr    = mem_q[iss_idx].wr;
  assign dbus.dreqbe    = mem_q[iss_idx].wr ? st_be : 4'hF;
  assign dbus.dreqwdata = st_wdata;
  assign dbus.drspready = (iss_q != rsp_q);

  assign iss_fire = dbus.dreqvalid & dbus.dreqready & clk_en_i;
  assign rsp_fire = dbus.drspvalid & dbus.drspready & clk_en_i;

  merlin_lsq_align u_align (
    .st_funct3_i (mem_q[iss_idx].funct3),
    .st_off_i    (mem_q[iss_idx].addr[1:0]),
    .st_data_i   (mem_q[iss_idx].data),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata),
    .ld_funct3_i (mem_q[rsp_idx].funct3),
    .ld_off_i    (mem_q[rsp_idx].addr[1:0]),
    .ld_raw_i    (dbus.drspdata),
    .ld_data_o   (ld_data)
  );

  always_comb begin
    mem_d      = mem_q;
    wr_d       = wr_q;
    iss_d      = iss_q;
    rsp_d      = rsp_q;
    ids_wr_d   = ids_wr_q;
    ids_addr_d = ids_addr_q;
    ids_data_d = ids_data_q;
    lerr_d     = lerr_q;
    serr_d     = serr_q;
    eaddr_d    = eaddr_q;
    if (clk_en_i) begin
      ids_wr_d = 1'b0;
      lerr_d   = 1'b0;
      serr_d   = 1'b0;
      if (enq) begin
        mem_d[wr_idx] = '{
          wr:     exs_sq_wr_i,
          funct3: exs_funct3_i,
          hpl:    exs_hpl_i,
          regd:   exs_regd_addr_i,
          addr:   exs_addr_i,
          data:   exs_regs2_data_i
        };
        wr_d = wr_q + ptr_t'(1);
      end
      if (iss_fire) iss_d = iss_q + ptr_t'(1);
      if (rsp_fire) begin
        rsp_d = rsp_q + ptr_t'(1);
        if (mem_q[rsp_idx].wr) begin
          serr_d = dbus.drspwerr;
          if (dbus.drspwerr) eaddr_d = mem_q[rsp_idx].addr;
        end else begin
          lerr_d     = dbus.drsprerr;
          ids_wr_d   = ~dbus.drsprerr
                     & (mem_q[rsp_idx].regd != 5'd0);
          ids_addr_d = mem_q[rsp_idx].regd;
          ids_data_d = ld_data;
          if (dbus.drsprerr) eaddr_d = mem_q[rsp_idx].addr;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q       <= '0;
      iss_q      <= '0;
      rsp_q      <= '0;
      ids_wr_q   <= 1'b0;
      ids_addr_q <= '0;
      ids_data_q <= '0;
      lerr_q     <= 1'b0;
      serr_q     <= 1'b0;
      eaddr_q    <= '0;
    end else begin
      wr_q       <= wr_d;
      iss_q      <= iss_d;
      rsp_q      <= rsp_d;
      ids_wr_q   <= ids_wr_d;
      ids_addr_q <= ids_addr_d;
      ids_data_q <= ids_data_d;
      lerr_q     <= lerr_d;
      serr_q     <= serr_d;
      eaddr_q    <= eaddr_d;
    end
  end

  assign ids_reg_wr_o    = ids_wr_q;
  assign ids_reg_addr_o  = ids_addr_q;
  assign ids_reg_data_o  = ids_data_q;
  assign hvec_lerr_o     = lerr_q;
  assign hvec_serr_o     = serr_q;
  assign hvec_err_addr_o = eaddr_q;

endmodule

// File: tb/tb_merlin_lsq.sv
// Bench for merlin_lsq: directed scenarios plus random traffic against
// a queue-based model of the load/store queue and its data port.
module tb_merlin_lsq;

`ifdef MERLIN_LSQ_MULTI_OUTSTANDING_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        clk_en_i;
  logic        exs_full_o;
  logic        exs_lq_wr_i;
  logic        exs_sq_wr_i;
  logic [2:0]  exs_funct3_i;
  logic [1:0]  exs_hpl_i;
  logic [4:0]  exs_regd_addr_i;
  logic [31:0] exs_regs2_data_i;
  logic [31:0] exs_addr_i;
  logic        ids_reg_wr_o;
  logic [4:0]  ids_reg_addr_o;
  logic [31:0] ids_reg_data_o;
  logic        hvec_lerr_o;
  logic        hvec_serr_o;
  logic [31:0] hvec_err_addr_o;

  merlin_lsq_if dbus ();

  merlin_lsq dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .clk_en_i         (clk_en_i),
    .exs_full_o       (exs_full_o),
    .exs_lq_wr_i      (exs_lq_wr_i),
    .exs_sq_wr_i      (exs_sq_wr_i),
    .exs_funct3_i     (exs_funct3_i),
    .exs_hpl_i        (exs_hpl_i),
    .exs_regd_addr_i  (exs_regd_addr_i),
    .exs_regs2_data_i (exs_regs2_data_i),
    .exs_addr_i       (exs_addr_i),
    .dbus             (dbus.master),
    .ids_reg_wr_o     (ids_reg_wr_o),
    .ids_reg_addr_o   (ids_reg_addr_o),
    .ids_reg_data_o   (ids_reg_data_o),
    .hvec_lerr_o      (hvec_lerr_o),
    .hvec_serr_o      (hvec_serr_o),
    .hvec_err_addr_o  (hvec_err_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        wr;
    bit [2:0]  f3;
    bit [1:0]  hpl;
    bit [4:0]  rd;
    bit [31:0] addr;
    bit [31:0] data;
  } op_t;

  op_t iss_q[$];
  op_t out_q[$];

  bit        m_wr;
  bit [4:0]  m_rd;
  bit [31:0] m_wdat;
  bit        m_lerr;
  bit        m_serr;
  bit [31:0] m_eaddr;

  bit        s_lq, s_sq, s_en, s_rdy, s_rv, s_rerr, s_werr;
  bit [2:0]  s_f3;
  bit [1:0]  s_hpl;
  bit [4:0]  s_rd;
  bit [31:0] s_addr, s_data, s_rdata;

  bit [3:0]  cap_be;
  bit [31:0] cap_wdata;
  bit        cap_wr;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int op_size(op_t o);
    return 1 << o.f3[1:0];
  endfunction

  function automatic logic [3:0] m_be(op_t o);
    int sz;
    if (!o.wr) return 4'hF;
    sz = op_size(o);
    return 4'(((1 << sz) - 1) << o.addr[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(op_t o);
    logic [31:0] w;
    int sz;
    sz = op_size(o);
    for (int i = 0; i < 4; i++)
      w[8*i +: 8] = o.data[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(op_t o, logic [31:0] raw);
    logic [31:0] v, mask;
    int sz;
    sz = op_size(o);
    v  = raw >> (8 * int'(o.addr[1:0]));
    if (sz == 4) return v;
    mask = (32'h1 << (8 * sz)) - 32'h1;
    v    = v & mask;
    if (!o.f3[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic idle_inputs();
    s_lq = 0; s_sq = 0; s_en = 1; s_rdy = 0; s_rv = 0;
    s_rerr = 0; s_werr = 0; s_f3 = 0; s_hpl = 0; s_rd = 0;
    s_addr = 0; s_data = 0; s_rdata = 0;
  endtask

  task automatic stage_op(input bit wr, input bit [2:0] f3,
                          input bit [31:0] addr, input bit [31:0] data,
                          input bit [4:0] rd);
    s_lq = !wr; s_sq = wr; s_f3 = f3; s_addr = addr;
    s_data = data; s_rd = rd; s_hpl = 2'd3;
  endtask

  // Check current outputs against the model, apply staged inputs,
  // advance the model across the next clock edge.
  task automatic step();
    bit   exp_v, full_b, n_wr, n_lerr, n_serr;
    op_t  o;
    int   cnt;
    cnt    = iss_q.size() + out_q.size();
    full_b = (cnt == DEPTH);
    exp_v  = (iss_q.size() > 0) && (MULTI || out_q.size() == 0);
    chk("full", exs_full_o, full_b);
    chk("dreqvalid", dbus.dreqvalid, exp_v);
    if (exp_v) begin
      o = iss_q[0];
      chk("dreqaddr", dbus.dreqaddr, o.addr & ~32'h3);
      chk("dreqwr", dbus.dreqwr, o.wr);
      chk("dreqhpl", dbus.dreqhpl, o.hpl);
      chk("dreqbe", dbus.dreqbe, m_be(o));
      if (o.wr) chk("dreqwdata", dbus.dreqwdata, m_wdata(o));
    end
    chk("drspready", dbus.drspready, out_q.size() != 0);
    chk("ids_wr", ids_reg_wr_o, m_wr);
    if (m_wr) begin
      chk("ids_addr", ids_reg_addr_o, m_rd);
      chk("ids_data", ids_reg_data_o, m_wdat);
    end
    chk("lerr", hvec_lerr_o, m_lerr);
    chk("serr", hvec_serr_o, m_serr);
    chk("err_addr", hvec_err_addr_o, m_eaddr);
    if (exp_v && s_rdy) begin
      cap_be = dbus.dreqbe; cap_wdata = dbus.dreqwdata;
      cap_wr = dbus.dreqwr;
    end
    assert (!((s_lq || s_sq) && s_en && full_b))
      else $error("bench enqueued into a full queue");

    clk_en_i = s_en; exs_lq_wr_i = s_lq; exs_sq_wr_i = s_sq;
    exs_funct3_i = s_f3; exs_hpl_i = s_hpl;
    exs_regd_addr_i = s_rd; exs_addr_i = s_addr;
    exs_regs2_data_i = s_data;
    dbus.dreqready = s_rdy; dbus.drspvalid = s_rv;
    dbus.drsprerr = s_rerr; dbus.drspwerr = s_werr;
    dbus.drspdata = s_rdata;

    if (s_en) begin
      n_wr = 0; n_lerr = 0; n_serr = 0;
      if (s_rv && out_q.size() > 0) begin
        o = out_q.pop_front();
        if (o.wr) begin
          n_serr = s_werr;
          if (s_werr) m_eaddr = o.addr;
        end else begin
          n_lerr = s_rerr;
          if (s_rerr) m_eaddr = o.addr;
          else if (o.rd != 0) begin
            n_wr = 1; m_rd = o.rd; m_wdat = m_load(o, s_rdata);
          end
        end
      end
      if (exp_v && s_rdy) out_q.push_back(iss_q.pop_front());
      if ((s_lq || s_sq) && !full_b) begin
        o.wr = s_sq; o.f3 = s_f3; o.hpl = s_hpl; o.rd = s_rd;
        o.addr = s_addr; o.data = s_data;
        iss_q.push_back(o);
      end
      m_wr = n_wr; m_lerr = n_lerr; m_serr = n_serr;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic model_reset();
    iss_q.delete(); out_q.delete();
    m_wr = 0; m_lerr = 0; m_serr = 0; m_eaddr = 0;
    m_rd = 0; m_wdat = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1; clk_en_i = 1;
    exs_lq_wr_i = 0; exs_sq_wr_i = 0;
    dbus.dreqready = 0; dbus.drspvalid = 0;
    dbus.drsprerr = 0; dbus.drspwerr = 0;
    repeat (2) @(negedge clk);
    reset_i = 0;
    model_reset();
  endtask

  // Enqueue, issue, respond; returns with writeback/error outputs visible.
  task automatic run_op(input bit wr, input bit [2:0] f3,
                        input bit [31:0] addr, input bit [31:0] data,
                        input bit [4:0] rd, input bit [31:0] rdata,
                        input bit err);
    stage_op(wr, f3, addr, data, rd);
    step();
    s_rdy = 1;
    step();
    s_rv = 1; s_rdata = rdata; s_rerr = err && !wr; s_werr = err && wr;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (iss_q.size() == 0 && out_q.size() == 0) break;
      s_rdy = 1; s_rv = 1; s_rdata = $urandom;
      step();
    end
    chk("drained", iss_q.size() + out_q.size(), 0);
  endtask

  initial begin
    bit [2:0] lf3 [5];
    lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    dbus.drspdata = 0;
    do_reset();

    chk("rst_full", exs_full_o, 0);
    chk("rst_dreqvalid", dbus.dreqvalid, 0);
    chk("rst_drspready", dbus.drspready, 0);
    chk("rst_ids_wr", ids_reg_wr_o, 0);
    chk("rst_lerr", hvec_lerr_o, 0);
    chk("rst_serr", hvec_serr_o, 0);
    chk("rst_err_addr", hvec_err_addr_o, 0);

    run_op(0, 3'b010, 32'h100, 0, 5, 32'hDEADBEEF, 0);
    chk("t1_wr", ids_reg_wr_o, 1);
    chk("t1_addr", ids_reg_addr_o, 5);
    chk("t1_data", ids_reg_data_o, 32'hDEADBEEF);

    run_op(0, 3'b000, 32'h103, 0, 3, 32'h80123456, 0);
    chk("t2_lb", ids_reg_data_o, 32'hFFFFFF80);
    run_op(0, 3'b100, 32'h103, 0, 3, 32'h80123456, 0);
    chk("t2_lbu", ids_reg_data_o, 32'h00000080);
    run_op(0, 3'b001, 32'h102, 0, 3, 32'h80011234, 0);
    chk("t2_lh", ids_reg_data_o, 32'hFFFF8001);

    run_op(1, 3'b000, 32'h101, 32'h000000AB, 0, 0, 0);
    chk("t3_be", cap_be, 4'b0010);
    chk("t3_wdata", cap_wdata, 32'hABABABAB);
    chk("t3_wr", cap_wr, 1);
    chk("t3_no_wb", ids_reg_wr_o, 0);

    for (int i = 0; i < 4; i++) begin
      stage_op(i[0], 3'b010, 32'h300 + 4 * i, 32'h11 * i, 5'(i + 8));
      step();
    end
    chk("t4_full", exs_full_o, 1);
    repeat (3) step();
    s_rdy = 1;
    step();
    chk("t4_still_full", exs_full_o, 1);
    s_rv = 1; s_rdata = 32'h5;
    step();
    chk("t4_full_drop", exs_full_o, 0);
    drain();

    run_op(0, 3'b010, 32'h200, 0, 7, 32'h1234, 1);
    chk("t5_lerr", hvec_lerr_o, 1);
    chk("t5_eaddr", hvec_err_addr_o, 32'h200);
    chk("t5_no_wb", ids_reg_wr_o, 0);
    step();
    chk("t5_pulse", hvec_lerr_o, 0);
    chk("t5_hold", hvec_err_addr_o, 32'h200);
    run_op(0, 3'b010, 32'h204, 0, 9, 32'hCAFE0001, 0);
    chk("t5_next", ids_reg_data_o, 32'hCAFE0001);

    stage_op(0, 3'b010, 32'h400, 0, 4);
    step();
    stage_op(0, 3'b010, 32'h404, 0, 6);
    s_rdy = 1;
    step();
    do_reset();
    chk("t6_valid", dbus.dreqvalid, 0);
    chk("t6_rspready", dbus.drspready, 0);
    chk("t6_full", exs_full_o, 0);
    chk("t6_ids_wr", ids_reg_wr_o, 0);
    run_op(0, 3'b010, 32'h500, 0, 10, 32'h0BADF00D, 0);
    chk("t6_new_lw", ids_reg_data_o, 32'h0BADF00D);

    for (int c = 0; c < 3000; c++) begin
      s_en  = ($urandom_range(0, 9) != 0);
      s_rdy = $urandom_range(0, 1);
      s_rv  = ($urandom_range(0, 2) != 0);
      s_rerr = ($urandom_range(0, 9) == 0);
      s_werr = ($urandom_range(0, 9) == 0);
      s_rdata = $urandom;
      if (iss_q.size() + out_q.size() < DEPTH &&
          $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) begin
          s_sq = 1; s_f3 = 3'($urandom_range(0, 2));
        end else begin
          s_lq = 1; s_f3 = lf3[$urandom_range(0, 4)];
        end
        s_addr = $urandom & ~((32'h1 << s_f3[1:0]) - 32'h1);
        s_data = $urandom; s_rd = 5'($urandom);
        s_hpl = 2'($urandom);
      end
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
